// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer scheduler: FSM states, grant codes and
// counter widths.
package buzzer_pkg;

    localparam int SEC_W = 8;
    localparam int SNZ_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHIME  = 3'd1,
        ST_ALARM  = 3'd2,
        ST_CD     = 3'd3,
        ST_SNOOZE = 3'd4
    } state_e;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_CHIME = 2'd1;
    localparam logic [1:0] SRC_ALARM = 2'd2;
    localparam logic [1:0] SRC_CD    = 2'd3;

    // Source code presented on GRANT for a given state; SNOOZE is silent.
    function automatic logic [1:0] grant_of(input state_e s);
        logic [1:0] g;
        g = SRC_NONE;
        case (s)
            ST_CHIME: g = SRC_CHIME;
            ST_ALARM: g = SRC_ALARM;
            ST_CD:    g = SRC_CD;
            default:  g = SRC_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/buzzer_scheduler_btn_sync_edge.sv
// Button conditioner: STAGES-flop synchronizer followed by a registered
// rising-edge detector. The event is a single-cycle pulse, STAGES+1 cycles
// after the raw input rises.
module btn_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic evt_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              evt_q;

    // Synchronize the raw button, then register a pulse on its rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], btn_i};
            prev_q <= sync_q[STAGES-1];
            evt_q  <= sync_q[STAGES-1] & ~prev_q;
        end
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/buzzer_scheduler.sv
// Single owner of the buzzer: arbitrates chime, alarm and countdown requests,
// handles stop / snooze / auto-silence, and acknowledges serviced sources.
module buzzer_scheduler
    import buzzer_pkg::*;
#(
    parameter int TIMEOUT_S   = 60,
    parameter int SNOOZE_S    = 300,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       TICK,
    input  logic       CHIME_REQ,
    input  logic       ALARM_REQ,
    input  logic       CD_REQ,
    input  logic       CHIME_TONE,
    input  logic       RING_TONE,
    input  logic       CS,
    input  logic       SNZ,
    output logic       AUDIO,
    output logic [1:0] GRANT,
    output logic       ACK_ALARM,
    output logic       ACK_CD,
    output logic       SNOOZING
);

    localparam logic [SEC_W-1:0] TIMEOUT_C = TIMEOUT_S[SEC_W-1:0];
    localparam logic [SNZ_W-1:0] SNOOZE_C  = SNOOZE_S[SNZ_W-1:0];

    state_e            state_q, state_d;
    logic [1:0]        grant_q;
    logic              audio_q, audio_d;
    logic              ack_alarm_q, ack_alarm_d;
    logic              ack_cd_q, ack_cd_d;
    logic              snoozing_q;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [SNZ_W-1:0]  snz_q, snz_d;
    logic              alarm_lock_q, cd_lock_q, chime_mute_q;
    logic              alarm_set, cd_set, chime_set;
    logic              cs_evt, snz_evt;
    logic              alarm_v, cd_v, chime_v;

    btn_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i (CP),
        .rst_ni(CR),
        .btn_i (CS),
        .evt_o (cs_evt)
    );

    btn_sync_edge #(.STAGES(SYNC_STAGES)) u_snz_sync (
        .clk_i (CP),
        .rst_ni(CR),
        .btn_i (SNZ),
        .evt_o (snz_evt)
    );

    assign alarm_v = ALARM_REQ & ~alarm_lock_q;
    assign cd_v    = CD_REQ    & ~cd_lock_q;
    assign chime_v = CHIME_REQ & ~chime_mute_q;

    // Next-state, counter and acknowledge logic; CS is tested first so it
    // overrides snooze, tick and timeout in the same cycle.
    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        snz_d       = snz_q;
        ack_alarm_d = 1'b0;
        ack_cd_d    = 1'b0;
        alarm_set   = 1'b0;
        cd_set      = 1'b0;
        chime_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cd_v)         state_d = ST_CD;
                else if (alarm_v) state_d = ST_ALARM;
                else if (chime_v) state_d = ST_CHIME;
            end
            ST_CHIME: begin
                if (cs_evt) begin
                    chime_set = 1'b1;
                    state_d   = ST_IDLE;
                end
                else if (cd_v)       state_d = ST_CD;
                else if (alarm_v)    state_d = ST_ALARM;
                else if (!CHIME_REQ) state_d = ST_IDLE;
            end
            ST_SNOOZE: begin
                if (cs_evt) begin
                    snz_d   = '0;
                    state_d = ST_IDLE;
                end else if (cd_v) begin
                    state_d = ST_CD;          // snz_cnt held while CD rings
                end else if (alarm_v) begin
                    snz_d   = '0;
                    state_d = ST_ALARM;
                end else if (snz_q == '0) begin
                    state_d = ST_ALARM;
                end else if (TICK) begin
                    if (snz_q == SNZ_W'(1)) begin
                        snz_d   = '0;
                        state_d = ST_ALARM;   // self-triggered re-ring
                    end else begin
                        snz_d = snz_q - SNZ_W'(1);
                    end
                end
            end
            ST_ALARM: begin
                if (cs_evt) begin
                    ack_alarm_d = 1'b1;
                    alarm_set   = 1'b1;
                    state_d     = ST_IDLE;
                end else if (cd_v) begin
                    state_d = ST_CD;          // preempted: no acknowledge
                end else if (snz_evt) begin
                    ack_alarm_d = 1'b1;
                    alarm_set   = 1'b1;
                    snz_d       = SNOOZE_C;
                    state_d     = ST_SNOOZE;
                end else if (sec_q >= TIMEOUT_C) begin
                    ack_alarm_d = 1'b1;
                    alarm_set   = 1'b1;
                    state_d     = ST_IDLE;
                end else if (TICK && sec_q != '1) begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end
            ST_CD: begin
                if (cs_evt || sec_q >= TIMEOUT_C) begin
                    ack_cd_d = 1'b1;
                    cd_set   = 1'b1;
                    state_d  = (snz_q != '0) ? ST_SNOOZE : ST_IDLE;
                end else if (TICK && sec_q != '1) begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q && (state_d == ST_ALARM || state_d == ST_CD))
            sec_d = '0;
    end

    // Tone gating uses the state currently held, so AUDIO trails GRANT by one.
    always_comb begin
        audio_d = 1'b0;
        case (state_q)
            ST_CHIME:       audio_d = CHIME_TONE;
            ST_ALARM, ST_CD: audio_d = RING_TONE;
            default:        audio_d = 1'b0;
        endcase
    end

    // State, outputs, counters and lockout flags; reset silences immediately.
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state_q      <= ST_IDLE;
            grant_q      <= SRC_NONE;
            audio_q      <= 1'b0;
            ack_alarm_q  <= 1'b0;
            ack_cd_q     <= 1'b0;
            snoozing_q   <= 1'b0;
            sec_q        <= '0;
            snz_q        <= '0;
            alarm_lock_q <= 1'b0;
            cd_lock_q    <= 1'b0;
            chime_mute_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_of(state_d);
            audio_q      <= audio_d;
            ack_alarm_q  <= ack_alarm_d;
            ack_cd_q     <= ack_cd_d;
            snoozing_q   <= (snz_d != '0);
            sec_q        <= sec_d;
            snz_q        <= snz_d;
            alarm_lock_q <= alarm_set | (alarm_lock_q & ALARM_REQ);
            cd_lock_q    <= cd_set    | (cd_lock_q    & CD_REQ);
            chime_mute_q <= chime_set | (chime_mute_q & CHIME_REQ);
        end
    end

    assign AUDIO     = audio_q;
    assign GRANT     = grant_q;
    assign ACK_ALARM = ack_alarm_q;
    assign ACK_CD    = ack_cd_q;
    assign SNOOZING  = snoozing_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Self-checking bench for buzzer_scheduler: scenario tasks with inline checks
// and a scoreboard queue of expected acknowledges.
module tb_buzzer_scheduler;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       TICK = 1'b0;
    logic       CHIME_REQ = 1'b0;
    logic       ALARM_REQ = 1'b0;
    logic       CD_REQ = 1'b0;
    logic       CHIME_TONE = 1'b0;
    logic       RING_TONE = 1'b0;
    logic       CS = 1'b0;
    logic       SNZ = 1'b0;
    logic       AUDIO;
    logic [1:0] GRANT;
    logic       ACK_ALARM;
    logic       ACK_CD;
    logic       SNOOZING;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    logic ring_hist = 1'b0;
    logic chime_hist = 1'b0;

    buzzer_scheduler #(.TIMEOUT_S(60), .SNOOZE_S(300), .SYNC_STAGES(2)) dut (
        .CP(CP), .CR(CR), .TICK(TICK), .CHIME_REQ(CHIME_REQ),
        .ALARM_REQ(ALARM_REQ), .CD_REQ(CD_REQ), .CHIME_TONE(CHIME_TONE),
        .RING_TONE(RING_TONE), .CS(CS), .SNZ(SNZ), .AUDIO(AUDIO),
        .GRANT(GRANT), .ACK_ALARM(ACK_ALARM), .ACK_CD(ACK_CD),
        .SNOOZING(SNOOZING)
    );

    always #5 CP = ~CP;

    // Random tones change shortly after each rising edge; *_hist holds the
    // value the DUT sampled at that edge.
    initial begin
        forever begin
            @(posedge CP);
            #2;
            ring_hist  = RING_TONE;
            chime_hist = CHIME_TONE;
            RING_TONE  = ($urandom_range(0, 1) == 1);
            CHIME_TONE = ($urandom_range(0, 1) == 1);
        end
    end

    // Scoreboard: every acknowledge pulse must match the next expected source.
    always @(negedge CP) begin
        int got, expv;
        if (CR && (ACK_ALARM || ACK_CD)) begin
            n_checks++;
            if (ACK_ALARM && ACK_CD) begin
                n_fail++;
                $display("FAIL ack_exclusive: ACK_ALARM=1 ACK_CD=1, required at most one");
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ack_unexpected: ACK_ALARM=%0b ACK_CD=%0b, required none", ACK_ALARM, ACK_CD);
            end else begin
                expv = exp_q.pop_front();
                got  = ACK_ALARM ? 2 : 3;
                if (got != expv) begin
                    n_fail++;
                    $display("FAIL ack_source: got %0d, required %0d", got, expv);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CP);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge CP); TICK = 1'b1;
            @(negedge CP); TICK = 1'b0;
        end
    endtask

    task automatic test_reset;
        CR = 1'b0;
        cyc(3);
        n_checks++;
        if ({AUDIO, GRANT, ACK_ALARM, ACK_CD, SNOOZING} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 000000", {AUDIO, GRANT, ACK_ALARM, ACK_CD, SNOOZING});
        end
        CR = 1'b1;
        cyc(3);
        n_checks++;
        if (GRANT !== 2'd0 || AUDIO !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: GRANT=%0d AUDIO=%0b, required 0 0", GRANT, AUDIO);
        end
    endtask

    task automatic test_alarm_stop;
        ALARM_REQ = 1'b1;
        cyc(2);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (GRANT !== 2'd2 || AUDIO !== ring_hist) begin
                n_fail++;
                $display("FAIL alarm_ring: GRANT=%0d AUDIO=%0b, required 2 %0b", GRANT, AUDIO, ring_hist);
            end
            if (i < 5) cyc(1);
        end
        exp_q.push_back(2);
        CS = 1'b1;
        cyc(3);
        n_checks++;
        if (ACK_ALARM !== 1'b0 || GRANT !== 2'd2) begin
            n_fail++;
            $display("FAIL stop_early: ACK_ALARM=%0b GRANT=%0d, required 0 2", ACK_ALARM, GRANT);
        end
        cyc(1);
        n_checks++;
        if (ACK_ALARM !== 1'b1 || GRANT !== 2'd0) begin
            n_fail++;
            $display("FAIL stop_ack: ACK_ALARM=%0b GRANT=%0d, required 1 0", ACK_ALARM, GRANT);
        end
        cyc(1);
        n_checks++;
        if (ACK_ALARM !== 1'b0 || AUDIO !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_silent: ACK_ALARM=%0b AUDIO=%0b, required 0 0", ACK_ALARM, AUDIO);
        end
        CS = 1'b0;
        cyc(10);
        n_checks++;
        if (GRANT !== 2'd0 || AUDIO !== 1'b0) begin
            n_fail++;
            $display("FAIL no_rering: GRANT=%0d AUDIO=%0b, required 0 0", GRANT, AUDIO);
        end
        ALARM_REQ = 1'b0;
        cyc(3);
    endtask

    task automatic test_timeout;
        bit found;
        CD_REQ = 1'b1;
        cyc(2);
        n_checks++;
        if (GRANT !== 2'd3) begin
            n_fail++;
            $display("FAIL cd_grant: GRANT=%0d, required 3", GRANT);
        end
        exp_q.push_back(3);
        tick_n(59);
        n_checks++;
        if (GRANT !== 2'd3) begin
            n_fail++;
            $display("FAIL cd_before_timeout: GRANT=%0d, required 3", GRANT);
        end
        tick_n(1);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            cyc(1);
            if (ACK_CD) found = 1'b1;
        end
        n_checks++;
        if (!found || GRANT !== 2'd0) begin
            n_fail++;
            $display("FAIL cd_timeout: ack_seen=%0b GRANT=%0d, required 1 0", found, GRANT);
        end
        cyc(1);
        n_checks++;
        if (AUDIO !== 1'b0) begin
            n_fail++;
            $display("FAIL cd_timeout_audio: AUDIO=%0b, required 0", AUDIO);
        end
        CD_REQ = 1'b0;
        cyc(3);
    endtask

    task automatic test_snooze;
        bit found;
        ALARM_REQ = 1'b1;
        cyc(2);
        n_checks++;
        if (GRANT !== 2'd2) begin
            n_fail++;
            $display("FAIL snz_alarm_grant: GRANT=%0d, required 2", GRANT);
        end
        exp_q.push_back(2);
        SNZ = 1'b1;
        cyc(4);
        n_checks++;
        if (SNOOZING !== 1'b1 || GRANT !== 2'd0) begin
            n_fail++;
            $display("FAIL snz_enter: SNOOZING=%0b GRANT=%0d, required 1 0", SNOOZING, GRANT);
        end
        SNZ = 1'b0;
        ALARM_REQ = 1'b0;
        cyc(1);
        tick_n(299);
        n_checks++;
        if (SNOOZING !== 1'b1 || GRANT !== 2'd0 || AUDIO !== 1'b0) begin
            n_fail++;
            $display("FAIL snz_hold: SNOOZING=%0b GRANT=%0d AUDIO=%0b, required 1 0 0", SNOOZING, GRANT, AUDIO);
        end
        tick_n(1);
        found = (GRANT == 2'd2);
        for (int i = 0; i < 4 && !found; i++) begin
            cyc(1);
            if (GRANT == 2'd2) found = 1'b1;
        end
        n_checks++;
        if (!found || SNOOZING !== 1'b0) begin
            n_fail++;
            $display("FAIL snz_expire: regrant=%0b SNOOZING=%0b, required 1 0", found, SNOOZING);
        end
        cyc(1);
        n_checks++;
        if (AUDIO !== ring_hist) begin
            n_fail++;
            $display("FAIL snz_rering_audio: AUDIO=%0b, required %0b", AUDIO, ring_hist);
        end
        exp_q.push_back(2);
        CS = 1'b1;
        cyc(5);
        n_checks++;
        if (GRANT !== 2'd0 || SNOOZING !== 1'b0) begin
            n_fail++;
            $display("FAIL snz_stop: GRANT=%0d SNOOZING=%0b, required 0 0", GRANT, SNOOZING);
        end
        CS = 1'b0;
        cyc(3);
    endtask

    task automatic test_preempt;
        bit found;
        CHIME_REQ = 1'b1;
        cyc(2);
        n_checks++;
        if (GRANT !== 2'd1 || AUDIO !== chime_hist) begin
            n_fail++;
            $display("FAIL chime_grant: GRANT=%0d AUDIO=%0b, required 1 %0b", GRANT, AUDIO, chime_hist);
        end
        ALARM_REQ = 1'b1;
        cyc(2);
        n_checks++;
        if (GRANT !== 2'd2) begin
            n_fail++;
            $display("FAIL alarm_over_chime: GRANT=%0d, required 2", GRANT);
        end
        CD_REQ = 1'b1;
        cyc(2);
        n_checks++;
        if (GRANT !== 2'd3 || AUDIO !== ring_hist) begin
            n_fail++;
            $display("FAIL cd_over_alarm: GRANT=%0d AUDIO=%0b, required 3 %0b", GRANT, AUDIO, ring_hist);
        end
        exp_q.push_back(3);
        CS = 1'b1;
        cyc(4);
        found = (GRANT == 2'd2);
        for (int i = 0; i < 6 && !found; i++) begin
            cyc(1);
            if (GRANT == 2'd2) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL alarm_rewin: GRANT=%0d, required 2", GRANT);
        end
        CS = 1'b0;
        CD_REQ = 1'b0;
        cyc(3);
        exp_q.push_back(2);
        CS = 1'b1;
        cyc(6);
        n_checks++;
        if (GRANT !== 2'd1) begin
            n_fail++;
            $display("FAIL chime_resume: GRANT=%0d, required 1", GRANT);
        end
        CS = 1'b0;
        cyc(3);
        CS = 1'b1;
        cyc(5);
        CS = 1'b0;
        cyc(5);
        n_checks++;
        if (GRANT !== 2'd0 || AUDIO !== 1'b0) begin
            n_fail++;
            $display("FAIL chime_mute: GRANT=%0d AUDIO=%0b, required 0 0", GRANT, AUDIO);
        end
        CHIME_REQ = 1'b0;
        ALARM_REQ = 1'b0;
        cyc(3);
    endtask

    task automatic test_simultaneous;
        ALARM_REQ = 1'b1;
        cyc(2);
        exp_q.push_back(2);
        CS  = 1'b1;
        SNZ = 1'b1;
        cyc(6);
        n_checks++;
        if (GRANT !== 2'd0 || SNOOZING !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_beats_snz: GRANT=%0d SNOOZING=%0b, required 0 0", GRANT, SNOOZING);
        end
        CS  = 1'b0;
        SNZ = 1'b0;
        ALARM_REQ = 1'b0;
        cyc(3);
        // Enter snooze, run it to one second left, then CS lands on the last TICK.
        ALARM_REQ = 1'b1;
        cyc(2);
        exp_q.push_back(2);
        SNZ = 1'b1;
        cyc(4);
        SNZ = 1'b0;
        ALARM_REQ = 1'b0;
        tick_n(299);
        CS = 1'b1;
        cyc(3);
        TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        n_checks++;
        if (GRANT !== 2'd0 || SNOOZING !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_beats_tick: GRANT=%0d SNOOZING=%0b, required 0 0", GRANT, SNOOZING);
        end
        CS = 1'b0;
        cyc(10);
        n_checks++;
        if (GRANT !== 2'd0 || AUDIO !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_tick_quiet: GRANT=%0d AUDIO=%0b, required 0 0", GRANT, AUDIO);
        end
    endtask

    task automatic test_reset_mid_ring;
        bit hi;
        ALARM_REQ = 1'b1;
        cyc(2);
        hi = (AUDIO == 1'b1);
        for (int i = 0; i < 40 && !hi; i++) begin
            cyc(1);
            if (AUDIO == 1'b1) hi = 1'b1;
        end
        n_checks++;
        if (!hi) begin
            n_fail++;
            $display("FAIL ring_audio_high: AUDIO never 1 within 40 cycles, required 1");
        end
        CR = 1'b0;
        #1;
        n_checks++;
        if (AUDIO !== 1'b0 || GRANT !== 2'd0 || ACK_ALARM !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: AUDIO=%0b GRANT=%0d ACK_ALARM=%0b, required 0 0 0", AUDIO, GRANT, ACK_ALARM);
        end
        cyc(2);
        CR = 1'b1;
        cyc(1);
        n_checks++;
        if (ACK_ALARM !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_ack: ACK_ALARM=%0b, required 0", ACK_ALARM);
        end
        cyc(1);
        n_checks++;
        if (GRANT !== 2'd2) begin
            n_fail++;
            $display("FAIL regrant_after_reset: GRANT=%0d, required 2", GRANT);
        end
        exp_q.push_back(2);
        CS = 1'b1;
        cyc(6);
        CS = 1'b0;
        ALARM_REQ = 1'b0;
        cyc(4);
    endtask

    initial begin
        test_reset();
        test_alarm_stop();
        test_timeout();
        test_snooze();
        test_preempt();
        test_simultaneous();
        test_reset_mid_ring();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ack_missing: %0d acknowledges outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/buzzer_scheduler.md
Name: buzzer_scheduler

Overview:
- Single owner of the buzzer output, shared by three requesters: hourly chime, alarm and countdown expiry.
- Arbitrates between them by fixed priority and gates the selected tone onto AUDIO.
- Handles stop (CS), snooze and auto-silence timeout, and returns one-cycle acknowledges so the alarm and countdown blocks can clear their TC flags.
- Sits between the alarm, countdown, chime and sound-generator blocks and the AUDIO pin of the clock top level.

Parameters:
- TIMEOUT_S, 60, seconds a ring state (alarm/countdown) lasts before auto-silence; range 1..255.
- SNOOZE_S, 300, snooze length in seconds; range 1..1023.
- SYNC_STAGES, 2, synchronizer flops on the CS/SNZ button inputs; minimum 2.

Ports:
- CP  in  1  system clock, the only clock.
- CR  in  1  reset; asynchronous, active-low.
- TICK  in  1  one-CP-cycle pulse per second, synchronous to CP.
- CHIME_REQ  in  1  level; hourly chime window active.
- ALARM_REQ  in  1  level; alarm TC.
- CD_REQ  in  1  level; countdown TC.
- CHIME_TONE  in  1  chime tone waveform, synchronous to CP.
- RING_TONE  in  1  alarm/countdown tone waveform, synchronous to CP.
- CS  in  1  stop button, raw and asynchronous.
- SNZ  in  1  snooze button, raw and asynchronous.
- AUDIO  out  1  buzzer drive, registered.
- GRANT  out  2  current source: 0 none, 1 chime, 2 alarm, 3 countdown.
- ACK_ALARM  out  1  one-cycle pulse; alarm serviced.
- ACK_CD  out  1  one-cycle pulse; countdown serviced.
- SNOOZING  out  1  high while snooze is pending.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters and lockout flags 0.
- Reset mid-ring forces AUDIO to 0 immediately (asynchronous) and issues no ACK.
- Button path: CS and SNZ each pass through SYNC_STAGES flops, then a rising-edge detector, giving a 1-cycle event. Total latency is SYNC_STAGES+1 cycles.
- States: IDLE, CHIME, ALARM, CD, SNOOZE.
- Request qualification:
  - alarm_v = ALARM_REQ & ~alarm_lock; cd_v = CD_REQ & ~cd_lock; chime_v = CHIME_REQ & ~chime_mute.
  - A lock or mute flag is set when its source is serviced and cleared when the raw REQ is low.
- Priority, evaluated every cycle in IDLE, CHIME and SNOOZE: cd_v > alarm_v > chime_v.
  - CD preempts every state except CD itself.
  - ALARM preempts CHIME and SNOOZE.
  - CHIME is entered only from IDLE.
- Preempted ALARM is not acknowledged. It re-wins arbitration after CD ends, provided ALARM_REQ is still high.
- CHIME: leave to IDLE when CHIME_REQ falls. A CS event sets chime_mute and goes to IDLE.
- ALARM and CD (ring states):
  - sec_cnt clears on entry and increments on TICK.
  - A CS event pulses that source's ACK, sets its lock and goes to IDLE.
  - sec_cnt reaching TIMEOUT_S gives the same ACK, lock and return to IDLE.
- SNZ event in ALARM:
  - pulse ACK_ALARM, set alarm_lock;
  - load snz_cnt = SNOOZE_S, go to SNOOZE, SNOOZING=1.
- SNZ is ignored in CD, CHIME and IDLE.
- SNOOZE:
  - snz_cnt decrements on TICK. At 0, enter ALARM (self-triggered, independent of ALARM_REQ) and drop SNOOZING.
  - A CS event cancels the snooze and goes to IDLE.
  - CD preemption freezes snz_cnt. After CD exits, return to SNOOZE if snz_cnt>0.
- Simultaneous events in the same cycle:
  - CS beats SNZ, TICK and timeout.
  - CD_REQ beats ALARM_REQ.
  - TICK with CS: the CS action only.
- ACK behaviour:
  - exactly one cycle, on the cycle the state leaves ALARM/CD;
  - never both ACKs in the same cycle.
- Audio timing:
  - GRANT is registered alongside the state.
  - AUDIO is registered from (state, tone) and lags GRANT by one cycle.
  - Request to AUDIO latency is 2 CP cycles.
- Tone selection: AUDIO = CHIME_TONE in CHIME, RING_TONE in ALARM/CD, 0 otherwise.
- Counter widths: sec_cnt 8 bits, snz_cnt 10 bits. Both saturate and never wrap.

Decomposition:
- Shared package buzzer_pkg:
  - state encoding (IDLE=0, CHIME=1, ALARM=2, CD=3, SNOOZE=4);
  - GRANT source codes;
  - counter widths.
- One sub-module: btn_sync_edge (parameter STAGES), instantiated for CS and SNZ.

Test Plan:
1. Alarm stop: ALARM_REQ=1 → after 2 cycles GRANT=2, AUDIO follows RING_TONE. CS press → after SYNC_STAGES+2 cycles ACK_ALARM pulses once, AUDIO=0. No re-ring while ALARM_REQ stays high.
2. Timeout: CD_REQ held, no CS. After 60 TICKs ACK_CD pulses, GRANT=0, AUDIO=0.
3. Snooze: during ALARM press SNZ → ACK_ALARM, SNOOZING=1, silent. After 300 TICKs GRANT=2 and ringing resumes; then CS → IDLE with SNOOZING=0.
4. Preemption: CHIME active (GRANT=1), raise ALARM_REQ → GRANT=2. Raise CD_REQ → GRANT=3 with no ACK_ALARM. CS → ACK_CD, then GRANT=2 again.
5. Simultaneous events: CS and SNZ edges in the same cycle while in ALARM → IDLE, SNOOZING stays 0. TICK coinciding with CS → no snooze or timeout action.
6. Reset mid-ring: pull CR low in ALARM → AUDIO=0 in the same cycle, no ACK. After release with ALARM_REQ still 1 → ALARM is re-granted after 2 cycles.
